// File: rtl/wishbone_arbiter_if.sv
// Wishbone classic bus bundle shared by the arbiter's upstream and downstream sides.
interface wishbone_if;
  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;

  logic             cyc;
  logic             stb;
  logic             we;
  logic [ADR_W-1:0] adr;
  logic [SEL_W-1:0] sel;
  logic [DAT_W-1:0] dat_w;
  logic [DAT_W-1:0] dat_r;
  logic             ack;
  logic             err;

  modport master (
    output cyc, stb, we, adr, sel, dat_w,
    input  dat_r, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_w,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wishbone_arbiter.sv
// N-master to 1-slave Wishbone arbiter with ownership held for the whole cyc
// and a watchdog that aborts stalled transfers.
// Build option: define ARBITER_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise the lowest requesting index wins.
module wishbone_arbiter #(
  parameter int unsigned N_MASTERS      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  wishbone_if.slave            m_bus [N_MASTERS],
  wishbone_if.master           s_bus,
  output logic [N_MASTERS-1:0] o_grant,
  output logic                 o_timeout
);

  localparam int unsigned IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int unsigned WD_W  = 16;
  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;
  localparam bit          WD_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                 state, state_n;
  logic [IDX_W-1:0]       grant_idx, grant_idx_n;
  logic [N_MASTERS-1:0]   grant_n;
  logic [WD_W-1:0]        wd_cnt, wd_n;
  logic                   timeout_c;
  logic                   busy_c;
  logic [N_MASTERS-1:0]   route_c;

  logic                   win_found;
  logic [IDX_W-1:0]       win_idx;

  logic [N_MASTERS-1:0]   m_cyc;
  logic [N_MASTERS-1:0]   m_stb;
  logic [N_MASTERS-1:0]   m_we;
  logic [ADR_W-1:0]       m_adr   [N_MASTERS];
  logic [SEL_W-1:0]       m_sel   [N_MASTERS];
  logic [DAT_W-1:0]       m_dat_w [N_MASTERS];

  logic                   g_cyc;
  logic                   g_stb;

`ifdef ARBITER_ROUND_ROBIN_EN
  logic [IDX_W-1:0]       rr_next, rr_next_n;
`endif

  // Flatten the upstream interface array and return slave responses to the owner only.
  for (genvar i = 0; i < N_MASTERS; i++) begin : g_port
    assign m_cyc[i]       = m_bus[i].cyc;
    assign m_stb[i]       = m_bus[i].stb;
    assign m_we[i]        = m_bus[i].we;
    assign m_adr[i]       = m_bus[i].adr;
    assign m_sel[i]       = m_bus[i].sel;
    assign m_dat_w[i]     = m_bus[i].dat_w;
    assign m_bus[i].ack   = route_c[i] & s_bus.ack;
    assign m_bus[i].err   = route_c[i] & (s_bus.err | timeout_c);
    assign m_bus[i].dat_r = route_c[i] ? s_bus.dat_r : '0;
  end

  assign busy_c  = (state == BUSY);
  assign route_c = busy_c ? o_grant : '0;
  assign g_cyc   = m_cyc[grant_idx];
  assign g_stb   = m_stb[grant_idx];

  // Downstream request lines follow the owner while BUSY and are parked low otherwise.
  assign s_bus.cyc   = busy_c & g_cyc;
  assign s_bus.stb   = busy_c & g_stb;
  assign s_bus.we    = busy_c & m_we[grant_idx];
  assign s_bus.adr   = busy_c ? m_adr[grant_idx]   : '0;
  assign s_bus.sel   = busy_c ? m_sel[grant_idx]   : '0;
  assign s_bus.dat_w = busy_c ? m_dat_w[grant_idx] : '0;

  assign o_timeout = timeout_c;

  // Arbitration winner among masters currently holding cyc.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
`ifdef ARBITER_ROUND_ROBIN_EN
    for (int k = 0; k < N_MASTERS; k++) begin
      int unsigned cand;
      cand = 32'(rr_next) + 32'(k);
      if (cand >= N_MASTERS) cand = cand - N_MASTERS;
      if (!win_found && m_cyc[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
`else
    for (int k = 0; k < N_MASTERS; k++) begin
      if (!win_found && m_cyc[k]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(k);
      end
    end
`endif
  end

  // Next-state, grant and watchdog logic.
  always_comb begin
    state_n     = state;
    grant_idx_n = grant_idx;
    grant_n     = o_grant;
    wd_n        = wd_cnt;
    timeout_c   = 1'b0;
    unique case (state)
      IDLE: begin
        grant_n = '0;
        wd_n    = '0;
        if (win_found) begin
          state_n          = BUSY;
          grant_idx_n      = win_idx;
          grant_n[win_idx] = 1'b1;
        end
      end
      BUSY: begin
        if (!g_cyc) begin
          state_n = IDLE;
          grant_n = '0;
          wd_n    = '0;
        end else if (s_bus.ack || s_bus.err) begin
          // A response at the threshold cycle still wins over the abort.
          wd_n = '0;
        end else if (WD_EN && (wd_cnt == WD_W'(TIMEOUT_CYCLES))) begin
          timeout_c = 1'b1;
          state_n   = DRAIN;
          wd_n      = '0;
        end else if (WD_EN && g_stb) begin
          wd_n = wd_cnt + WD_W'(1);
        end
      end
      DRAIN: begin
        wd_n = '0;
        if (!g_cyc) begin
          state_n = IDLE;
          grant_n = '0;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        wd_n    = '0;
      end
    endcase
  end

  // State, owner and watchdog registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant_idx <= '0;
      o_grant   <= '0;
      wd_cnt    <= '0;
    end else begin
      state     <= state_n;
      grant_idx <= grant_idx_n;
      o_grant   <= grant_n;
      wd_cnt    <= wd_n;
    end
  end

`ifdef ARBITER_ROUND_ROBIN_EN
  // Round-robin pointer: index that gets first look at the next arbitration.
  always_comb begin
    rr_next_n = rr_next;
    if (state == IDLE && win_found) begin
      rr_next_n = (win_idx == IDX_W'(N_MASTERS - 1)) ? '0 : win_idx + IDX_W'(1);
    end
  end

  // Pointer register; reset gives master 0 first look.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_next <= '0;
    end else begin
      rr_next <= rr_next_n;
    end
  end
`endif

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed self-checking bench for wishbone_arbiter (two masters, watchdog of 4).
module tb_wishbone_arbiter;

  logic        clk;
  logic        reset;

  logic [1:0]  m_cyc, m_stb, m_we;
  logic [31:0] m_adr   [2];
  logic [3:0]  m_sel   [2];
  logic [31:0] m_dat_w [2];
  logic [1:0]  m_ack_o, m_err_o;
  logic [31:0] m_dat_r_o [2];

  logic        s_ack, s_err;
  logic [31:0] s_dat_r;
  logic        s_cyc_o, s_stb_o;
  logic [31:0] s_adr_o;

  logic [1:0]  grant;
  logic        timeout;

  int n_assert;
  int n_fail;

  wishbone_if m_bus [2] ();
  wishbone_if s_bus ();

  for (genvar i = 0; i < 2; i++) begin : g_m
    assign m_bus[i].cyc   = m_cyc[i];
    assign m_bus[i].stb   = m_stb[i];
    assign m_bus[i].we    = m_we[i];
    assign m_bus[i].adr   = m_adr[i];
    assign m_bus[i].sel   = m_sel[i];
    assign m_bus[i].dat_w = m_dat_w[i];
    assign m_ack_o[i]     = m_bus[i].ack;
    assign m_err_o[i]     = m_bus[i].err;
    assign m_dat_r_o[i]   = m_bus[i].dat_r;
  end

  assign s_bus.ack   = s_ack;
  assign s_bus.err   = s_err;
  assign s_bus.dat_r = s_dat_r;
  assign s_cyc_o     = s_bus.cyc;
  assign s_stb_o     = s_bus.stb;
  assign s_adr_o     = s_bus.adr;

  wishbone_arbiter #(
    .N_MASTERS      (2),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .m_bus     (m_bus),
    .s_bus     (s_bus),
    .o_grant   (grant),
    .o_timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] exp_g;
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    m_cyc    = '0;
    m_stb    = '0;
    m_we     = '0;
    s_ack    = 1'b0;
    s_err    = 1'b0;
    s_dat_r  = '0;
    for (int i = 0; i < 2; i++) begin
      m_adr[i]   = '0;
      m_sel[i]   = 4'hF;
      m_dat_w[i] = '0;
    end
    #1;
    chk("rst_grant",   32'(grant),   32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_s_cyc",   32'(s_cyc_o), 32'd0);
    chk("rst_m_ack",   32'(m_ack_o), 32'd0);
    chk("rst_m_err",   32'(m_err_o), 32'd0);
    step();
    step();
    reset = 1'b0;

    // Single master read from master 1, ack after three wait cycles.
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h0000_0100;
    #1;
    chk("a_grant_latency", 32'(grant),   32'd0);
    chk("a_idle_s_cyc",    32'(s_cyc_o), 32'd0);
    step();
    chk("a_grant",  32'(grant),   32'h2);
    chk("a_s_cyc",  32'(s_cyc_o), 32'd1);
    chk("a_s_adr",  s_adr_o,      32'h0000_0100);
    step(); step(); step();
    s_ack = 1'b1; s_dat_r = 32'hDEAD_BEEF;
    #1;
    chk("a_ack",        32'(m_ack_o),  32'h2);
    chk("a_dat_r",      m_dat_r_o[1],  32'hDEAD_BEEF);
    chk("a_dat_r_m0",   m_dat_r_o[0],  32'd0);
    chk("a_no_timeout", 32'(timeout),  32'd0);
    step();
    s_ack = 1'b0; s_dat_r = '0; m_cyc = '0; m_stb = '0;
    #1;
    chk("a_release_s_cyc", 32'(s_cyc_o), 32'd0);
    step();
    chk("a_idle_grant", 32'(grant), 32'd0);

    // Both masters request together, four rounds; losers withdraw.
    for (int r = 0; r < 4; r++) begin
`ifdef ARBITER_ROUND_ROBIN_EN
      exp_g = (r % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      m_cyc = 2'b11; m_stb = 2'b11;
      m_adr[0] = 32'h1000 + 32'(r); m_adr[1] = 32'h2000 + 32'(r);
      step();
      chk("b_grant", 32'(grant), 32'(exp_g));
      chk("b_s_adr", s_adr_o, exp_g[0] ? 32'h1000 + 32'(r) : 32'h2000 + 32'(r));
      s_ack = 1'b1;
      #1;
      chk("b_ack", 32'(m_ack_o), 32'(exp_g));
      step();
      s_ack = 1'b0; m_cyc = '0; m_stb = '0;
      step();
      chk("b_idle_grant", 32'(grant), 32'd0);
    end

    // Master 0 holds cyc over three beats while master 1 waits.
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h3000;
    step();
    chk("c_grant0", 32'(grant), 32'h1);
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h4000; s_ack = 1'b1;
    for (int b = 0; b < 3; b++) begin
      #1;
      chk("c_beat_ack",   32'(m_ack_o), 32'h1);
      chk("c_beat_grant", 32'(grant),   32'h1);
      step();
    end
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    #1;
    chk("c_m1_wait_ack", 32'(m_ack_o), 32'd0);
    chk("c_hold_grant",  32'(grant),   32'h1);
    step();
    chk("c_idle_grant", 32'(grant), 32'd0);
    step();
    chk("c_grant1", 32'(grant), 32'h2);
    chk("c_s_adr1", s_adr_o,    32'h4000);
    s_ack = 1'b1;
    #1;
    chk("c_ack1", 32'(m_ack_o), 32'h2);
    step();
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    step();

    // Watchdog abort: slave never responds.
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h5000;
    step();
    chk("d_c1_timeout", 32'(timeout), 32'd0);
    chk("d_c1_err",     32'(m_err_o), 32'd0);
    step(); step(); step();
    chk("d_c4_timeout", 32'(timeout), 32'd0);
    step();
    chk("d_timeout", 32'(timeout), 32'd1);
    chk("d_err",     32'(m_err_o), 32'h1);
    chk("d_no_ack",  32'(m_ack_o), 32'd0);
    step();
    chk("d_drain_s_cyc",   32'(s_cyc_o), 32'd0);
    chk("d_drain_s_stb",   32'(s_stb_o), 32'd0);
    chk("d_drain_timeout", 32'(timeout), 32'd0);
    chk("d_drain_err",     32'(m_err_o), 32'd0);
    chk("d_drain_grant",   32'(grant),   32'h1);
    step();
    chk("d_drain2_s_cyc", 32'(s_cyc_o), 32'd0);
    m_cyc = '0; m_stb = '0;
    step();
    chk("d_idle_grant", 32'(grant), 32'd0);

    // Ack on the threshold cycle wins over the abort.
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h5100;
    step(); step(); step(); step(); step();
    s_ack = 1'b1;
    #1;
    chk("f_timeout", 32'(timeout), 32'd0);
    chk("f_err",     32'(m_err_o), 32'd0);
    chk("f_ack",     32'(m_ack_o), 32'h2);
    step();
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    step();

    // Reset in the middle of a transfer.
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h6000;
    step();
    chk("e_grant", 32'(grant),   32'h2);
    chk("e_s_cyc", 32'(s_cyc_o), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("e_rst_s_cyc", 32'(s_cyc_o), 32'd0);
    chk("e_rst_grant", 32'(grant),   32'd0);
    chk("e_rst_err",   32'(m_err_o), 32'd0);
    m_cyc = '0; m_stb = '0;
    step();
    reset = 1'b0;
    m_cyc = 2'b11; m_stb = 2'b11; m_adr[0] = 32'h7000; m_adr[1] = 32'h8000;
    #1;
    chk("e_idle_grant", 32'(grant), 32'd0);
    step();
    chk("e_after_grant", 32'(grant), 32'h1);
    chk("e_after_s_adr", s_adr_o,    32'h7000);
    s_ack = 1'b1;
    #1;
    chk("e_after_ack", 32'(m_ack_o), 32'h1);
    step();
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wishbone_arbiter.md
WISHBONE_ARBITER -- requirements
Module: wishbone_arbiter

Interface
REQ-001 SHALL provide parameter N_MASTERS, default 2, number of upstream Wishbone masters (index 0 = instruction fetch, 1 = load/store); legal range 2..8.
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 255, cycles without ack before watchdog abort; 0 disables the watchdog.
REQ-003 SHALL provide port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port m_bus  wishbone_if.slave array [N_MASTERS]  upstream masters; carries cyc, stb, we, adr[31:0], sel[3:0], dat_w[31:0], dat_r[31:0], ack, err.
REQ-006 SHALL provide port s_bus  wishbone_if.master  1 bundle  shared downstream bus, same signal set.
REQ-007 SHALL provide port o_grant  output  N_MASTERS  one-hot current owner, all-zero when idle (debug LEDs).
REQ-008 SHALL provide port o_timeout  output  1  one-cycle pulse on watchdog abort.

Function
REQ-009 SHALL implement states IDLE, BUSY, DRAIN.
REQ-010 IDLE: when any m_bus[i].cyc is high, SHALL register a grant to the arbitration winner and enter BUSY next cycle; one idle cycle of grant latency.
REQ-011 BUSY: s_bus cyc, stb, we, adr, sel, dat_w SHALL be combinationally driven from the granted master; non-granted masters see ack=0, err=0.
REQ-012 s_bus ack, err and dat_r SHALL route combinationally to the granted master only, zero-latency.
REQ-013 BUSY SHALL hold ownership while the granted master's cyc is high (multi-beat/locked cycles not interrupted); cyc low returns to IDLE next cycle.
REQ-014 Requests arriving in BUSY SHALL wait; a master's cyc dropped before grant is forgotten.
REQ-015 Watchdog: 16-bit counter SHALL increment each BUSY cycle with stb high and ack/err low, and clear on ack, err or IDLE.
REQ-016 When counter equals TIMEOUT_CYCLES, SHALL assert err to the granted master and o_timeout for exactly one cycle, force s_bus cyc/stb low, and enter DRAIN.
REQ-017 DRAIN SHALL hold s_bus cyc low until the granted master drops cyc, then return to IDLE.
REQ-018 ack arriving in the same cycle as the timeout threshold SHALL win; no err, no abort.
REQ-019 In IDLE and DRAIN, s_bus cyc and stb SHALL be 0; o_grant SHALL be zero in IDLE.

Reset
REQ-020 Reset SHALL asynchronously force state IDLE, o_grant 0, o_timeout 0, watchdog 0, s_bus cyc/stb/we 0, all m_bus ack/err 0.
REQ-021 Reset asserted mid-transfer SHALL abandon the transfer without err; the round-robin pointer SHALL reset to master 0.

Configuration
REQ-022 Macro ARBITER_ROUND_ROBIN_EN defined: winner is the first requesting index after the last granted index (wrapping N_MASTERS-1 -> 0); pointer updates on each grant.
REQ-023 Macro ARBITER_ROUND_ROBIN_EN undefined: fixed priority, lowest requesting index wins; no pointer register.

Verification
REQ-024 Single master: m_bus[1] read adr 0x0000_0100, slave acks after 3 cycles with 0xDEAD_BEEF -> o_grant=2'b10 one cycle after cyc, m_bus[1] dat_r=0xDEAD_BEEF with ack, IDLE next cycle.
REQ-025 Simultaneous cyc on masters 0 and 1, repeated 4 times -> fixed: 0 always first; round-robin: grants alternate 0,1,0,1.
REQ-026 Master 0 holds cyc over 3 beats while master 1 requests -> master 1 granted only after master 0 drops cyc; master 1 sees no ack meanwhile.
REQ-027 TIMEOUT_CYCLES=4, slave never acks -> err and o_timeout high in 5th stb cycle, s_bus cyc low next cycle, DRAIN until master drops cyc.
REQ-028 reset pulsed during BUSY -> s_bus cyc and o_grant 0 without clock edge; next request served normally from master 0 priority.
